// File: rtl/sdram_state_fsm.sv
// sdram_state_fsm
//   Timing/state sequencer for the SDRAM controller. Runs the power-up init
//   sequence, then arbitrates between periodic auto-refresh and single-burst
//   read/write transactions. The command encoder downstream decodes
//   init_state/work_state/cnt_clk/sdram_rd_wr into SDRAM commands.
//
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   sdram_wr_req    write transaction request (level)
//   sdram_rd_req    read transaction request (level)
//   sdram_wr_burst  write burst length, 2..512
//   sdram_rd_burst  read burst length, 1..512
//   init_state      init state code
//   work_state      work state code
//   cnt_clk         cycles spent in the current state (saturates at 1023)
//   sdram_rd_wr     1 = read transaction, 0 = write transaction
//   sdram_init_done init sequence complete
//   sdram_wr_ack    write-data request to the FIFO (one cycle ahead of data)
//   sdram_rd_ack    read data valid window
module sdram_state_fsm #(
  parameter int INIT_WAIT  = 20000,
  parameter int TRP_CLK    = 4,
  parameter int TRFC_CLK   = 7,
  parameter int TRSC_CLK   = 6,
  parameter int TRCD_CLK   = 2,
  parameter int TCL_CLK    = 3,
  parameter int TWR_CLK    = 2,
  parameter int AR_TIMES   = 8,
  parameter int REF_PERIOD = 781
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic [4:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk,
  output logic       sdram_rd_wr,
  output logic       sdram_init_done,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack
);

  typedef enum logic [4:0] {
    I_NOP  = 5'd0, I_PRE = 5'd1, I_TRP  = 5'd2, I_AR   = 5'd3,
    I_TRF  = 5'd4, I_MRS = 5'd5, I_TRSC = 5'd6, I_DONE = 5'd7
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE  = 4'd0,  W_ACTIVE = 4'd1,  W_TRCD = 4'd2, W_READ = 4'd3,
    W_CL    = 4'd4,  W_RD     = 4'd5,  W_WRITE = 4'd6, W_WD  = 4'd7,
    W_TWR   = 4'd8,  W_PRE    = 4'd9,  W_TRP  = 4'd10, W_AR  = 4'd11,
    W_TRFC  = 4'd12
  } work_state_t;

  // Last cycle (cnt_clk value) of each fixed-length wait state
  localparam logic [9:0]  TRP_LAST  = 10'(TRP_CLK - 1);
  localparam logic [9:0]  TRFC_LAST = 10'(TRFC_CLK - 1);
  localparam logic [9:0]  TRSC_LAST = 10'(TRSC_CLK - 1);
  localparam logic [9:0]  TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0]  TCL_LAST  = 10'(TCL_CLK - 1);
  localparam logic [9:0]  TWR_LAST  = 10'(TWR_CLK - 1);
  localparam logic [14:0] INIT_LAST = 15'(INIT_WAIT - 1);
  localparam logic [15:0] REF_LAST  = 16'(REF_PERIOD - 1);
  localparam logic [7:0]  AR_TOTAL  = 8'(AR_TIMES);

  init_state_t init_state_q, init_state_d;
  work_state_t work_state_q, work_state_d;
  logic [9:0]  cnt_clk_q, cnt_clk_d;
  logic [14:0] init_cnt_q, init_cnt_d;
  logic [7:0]  ar_cnt_q, ar_cnt_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_req_q, ref_req_d;
  logic        rd_wr_q, rd_wr_d;
  logic        init_done;

  assign init_done = (init_state_q == I_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_state_q <= I_NOP;
      work_state_q <= W_IDLE;
      cnt_clk_q    <= '0;
      init_cnt_q   <= '0;
      ar_cnt_q     <= '0;
      ref_cnt_q    <= '0;
      ref_req_q    <= 1'b0;
      rd_wr_q      <= 1'b1;
    end else begin
      init_state_q <= init_state_d;
      work_state_q <= work_state_d;
      cnt_clk_q    <= cnt_clk_d;
      init_cnt_q   <= init_cnt_d;
      ar_cnt_q     <= ar_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_req_q    <= ref_req_d;
      rd_wr_q      <= rd_wr_d;
    end
  end

  // Init sequence
  always_comb begin
    init_state_d = init_state_q;
    init_cnt_d   = init_cnt_q;
    ar_cnt_d     = ar_cnt_q;
    case (init_state_q)
      I_NOP: begin
        if (init_cnt_q == INIT_LAST) init_state_d = I_PRE;
        else                         init_cnt_d   = init_cnt_q + 15'd1;
      end
      I_PRE:  init_state_d = I_TRP;
      I_TRP:  if (cnt_clk_q == TRP_LAST) init_state_d = I_AR;
      I_AR: begin
        ar_cnt_d     = ar_cnt_q + 8'd1;
        init_state_d = I_TRF;
      end
      I_TRF: begin
        if (cnt_clk_q == TRFC_LAST)
          init_state_d = (ar_cnt_q == AR_TOTAL) ? I_MRS : I_AR;
      end
      I_MRS:  init_state_d = I_TRSC;
      I_TRSC: if (cnt_clk_q == TRSC_LAST) init_state_d = I_DONE;
      I_DONE: init_state_d = I_DONE;
      default: init_state_d = I_NOP;
    endcase
  end

  // Work FSM; held in W_IDLE until init completes
  always_comb begin
    work_state_d = work_state_q;
    rd_wr_d      = rd_wr_q;
    if (init_done) begin
      case (work_state_q)
        W_IDLE: begin
          if (ref_req_q) begin
            work_state_d = W_AR;
          end else if (sdram_wr_req) begin
            work_state_d = W_ACTIVE;
            rd_wr_d      = 1'b0;
          end else if (sdram_rd_req) begin
            work_state_d = W_ACTIVE;
            rd_wr_d      = 1'b1;
          end
        end
        W_ACTIVE: work_state_d = W_TRCD;
        W_TRCD: if (cnt_clk_q == TRCD_LAST) work_state_d = rd_wr_q ? W_READ : W_WRITE;
        W_WRITE: work_state_d = W_WD;
        W_WD:   if (cnt_clk_q == sdram_wr_burst - 10'd1) work_state_d = W_TWR;
        W_TWR:  if (cnt_clk_q == TWR_LAST) work_state_d = W_PRE;
        W_READ: work_state_d = W_CL;
        W_CL:   if (cnt_clk_q == TCL_LAST) work_state_d = W_RD;
        // Read data arrives one cycle into W_RD, so it runs one cycle longer
        W_RD:   if (cnt_clk_q == sdram_rd_burst) work_state_d = W_PRE;
        W_PRE:  work_state_d = W_TRP;
        W_TRP:  if (cnt_clk_q == TRP_LAST) work_state_d = W_IDLE;
        W_AR:   work_state_d = W_TRFC;
        W_TRFC: if (cnt_clk_q == TRFC_LAST) work_state_d = W_IDLE;
        default: work_state_d = W_IDLE;
      endcase
    end
  end

  // Refresh timer and single-entry request flag. A wrap on the same edge
  // as W_AR entry re-arms the flag so that refresh is not lost.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    ref_req_d = ref_req_q;
    if (work_state_d == W_AR && work_state_q != W_AR) ref_req_d = 1'b0;
    if (init_done) begin
      if (ref_cnt_q == REF_LAST) begin
        ref_cnt_d = '0;
        ref_req_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 16'd1;
      end
    end
  end

  // Per-state cycle counter
  always_comb begin
    cnt_clk_d = cnt_clk_q;
    if (init_state_d != init_state_q || work_state_d != work_state_q)
      cnt_clk_d = '0;
    else if (cnt_clk_q != 10'd1023)
      cnt_clk_d = cnt_clk_q + 10'd1;
  end

  assign init_state      = init_state_q;
  assign work_state      = work_state_q;
  assign cnt_clk         = cnt_clk_q;
  assign sdram_rd_wr     = rd_wr_q;
  assign sdram_init_done = init_done;

  // Write ack leads the data bus by one cycle: starts on the last W_TRCD
  // cycle and stops two cycles before the end of W_WD.
  assign sdram_wr_ack = !rd_wr_q &&
                        ((work_state_q == W_TRCD && cnt_clk_q == TRCD_LAST) ||
                         (work_state_q == W_WRITE) ||
                         (work_state_q == W_WD && cnt_clk_q < sdram_wr_burst - 10'd2));

  assign sdram_rd_ack = (work_state_q == W_RD) && (cnt_clk_q >= 10'd1) &&
                        (cnt_clk_q <= sdram_rd_burst);

endmodule

// File: tb/tb_sdram_state_fsm.sv
module tb_sdram_state_fsm;

  // Event codes reported by the monitor
  localparam int EV_IS = 0;  // init_state change: (prev duration<<8) | new state
  localparam int EV_DN = 1;  // init_done rise: cycles since reset release
  localparam int EV_WS = 2;  // work_state change: (prev dur<<8)|(rd_wr<<7)|state
  localparam int EV_WR = 3;  // wr_ack rise: (work_state<<10) | cnt_clk
  localparam int EV_WF = 4;  // wr_ack fall: pulse length
  localparam int EV_RR = 5;  // rd_ack rise: cnt_clk
  localparam int EV_RF = 6;  // rd_ack fall: pulse length

  localparam int M_ALL   = 32'hFFFF_FFFF;
  localparam int M_NODUR = 32'h0000_00FF;  // ignore duration of previous state
  localparam int M_STATE = 32'hFFFF_FF7F;  // ignore rd_wr bit

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdram_wr_req = 1'b0;
  logic       sdram_rd_req = 1'b0;
  logic [9:0] sdram_wr_burst = 10'd8;
  logic [9:0] sdram_rd_burst = 10'd4;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;
  logic       sdram_rd_wr;
  logic       sdram_init_done;
  logic       sdram_wr_ack;
  logic       sdram_rd_ack;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int code;
    int val;
    int mask;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sdram_state_fsm #(
    .INIT_WAIT(10), .TRP_CLK(4), .TRFC_CLK(7), .TRSC_CLK(6), .TRCD_CLK(2),
    .TCL_CLK(3), .TWR_CLK(2), .AR_TIMES(2), .REF_PERIOD(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
    .init_state(init_state), .work_state(work_state), .cnt_clk(cnt_clk),
    .sdram_rd_wr(sdram_rd_wr), .sdram_init_done(sdram_init_done),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack)
  );

  function automatic string ev_name(input int code);
    case (code)
      EV_IS:   return "init_state";
      EV_DN:   return "init_done";
      EV_WS:   return "work_state";
      EV_WR:   return "wr_ack_rise";
      EV_WF:   return "wr_ack_len";
      EV_RR:   return "rd_ack_rise";
      EV_RF:   return "rd_ack_len";
      default: return "unknown";
    endcase
  endfunction

  // ---------------- scoreboard side ----------------
  task automatic push(input int code, input int val, input int mask);
    exp_t e;
    e.code = code;
    e.val  = val;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic push_ws(input int st, input int rdwr, input int dur, input int mask);
    push(EV_WS, (dur << 8) | (rdwr << 7) | st, mask);
  endtask

  task automatic push_init_seq();
    push(EV_IS, 1, M_NODUR);         // I_NOP -> I_PRE
    push(EV_IS, (1 << 8) | 2, M_ALL); // I_PRE 1 -> I_TRP
    push(EV_IS, (4 << 8) | 3, M_ALL); // I_TRP 4 -> I_AR
    push(EV_IS, (1 << 8) | 4, M_ALL); // I_AR  1 -> I_TRF
    push(EV_IS, (7 << 8) | 3, M_ALL); // I_TRF 7 -> I_AR
    push(EV_IS, (1 << 8) | 4, M_ALL);
    push(EV_IS, (7 << 8) | 5, M_ALL); // I_TRF 7 -> I_MRS
    push(EV_IS, (1 << 8) | 6, M_ALL); // I_MRS 1 -> I_TRSC
    push(EV_IS, (6 << 8) | 7, M_ALL); // I_TRSC 6 -> I_DONE
    push(EV_DN, 38, M_ALL);           // 10+1+4+2*(1+7)+1+6
  endtask

  task automatic push_refresh();
    push_ws(11, 0, 0, M_NODUR & M_STATE);
    push_ws(12, 0, 1, M_STATE);
    push_ws(0, 0, 7, M_STATE);
  endtask

  task automatic push_write(input int burst);
    push_ws(1, 0, 0, M_NODUR);
    push_ws(2, 0, 1, M_ALL);
    push(EV_WR, (2 << 10) | 1, M_ALL);  // last W_TRCD cycle
    push_ws(6, 0, 2, M_ALL);
    push_ws(7, 0, 1, M_ALL);
    push(EV_WF, burst, M_ALL);
    push_ws(8, 0, burst, M_ALL);
    push_ws(9, 0, 2, M_ALL);
    push_ws(10, 0, 1, M_ALL);
    push_ws(0, 0, 4, M_ALL);
  endtask

  task automatic push_read(input int burst, input bit partial);
    push_ws(1, 1, 0, M_NODUR);
    push_ws(2, 1, 1, M_ALL);
    push_ws(3, 1, 2, M_ALL);
    push_ws(4, 1, 1, M_ALL);
    push_ws(5, 1, 3, M_ALL);
    push(EV_RR, 1, M_ALL);
    if (!partial) begin
      push_ws(9, 1, burst + 1, M_ALL);
      push(EV_RF, burst, M_ALL);
      push_ws(10, 1, 1, M_ALL);
      push_ws(0, 1, 4, M_ALL);
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_init_state"}, int'(init_state), 0);
    chk({tag, "_work_state"}, int'(work_state), 0);
    chk({tag, "_cnt_clk"}, int'(cnt_clk), 0);
    chk({tag, "_rd_wr"}, int'(sdram_rd_wr), 1);
    chk({tag, "_init_done"}, int'(sdram_init_done), 0);
    chk({tag, "_wr_ack"}, int'(sdram_wr_ack), 0);
    chk({tag, "_rd_ack"}, int'(sdram_rd_ack), 0);
  endtask

  task automatic wait_ws(input int st, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (int'(work_state) == st) hit = 1;
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_work_state: got %0d expected %0d within %0d cycles",
               work_state, st, budget);
    end
  endtask

  task automatic wait_is(input int st, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (int'(init_state) == st) hit = 1;
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_init_state: got %0d expected %0d within %0d cycles",
               init_state, st, budget);
    end
  endtask

  task automatic do_refresh();
    push_refresh();
    wait_ws(12, 100);
    wait_ws(0, 20);
  endtask

  // ---------------- monitor ----------------
  task automatic emit(input int code, input int val);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected nothing (unexpected event)", ev_name(code), val);
    end else begin
      e = exp_q.pop_front();
      if (e.code != code || ((val ^ e.val) & e.mask) != 0) begin
        miscompares++;
        $display("FAIL %s: got %s 0x%0h expected %s 0x%0h (mask 0x%0h)",
                 ev_name(code), ev_name(code), val, ev_name(e.code), e.val, e.mask);
      end else begin
        $display("ok   %s 0x%0h", ev_name(code), val);
      end
    end
  endtask

  initial begin
    logic [4:0] p_is;
    logic [3:0] p_ws;
    logic       p_wa, p_ra, p_done;
    int d_is, d_ws, rel_cnt, wa_len, ra_len;
    p_is = '0; p_ws = '0; p_wa = 0; p_ra = 0; p_done = 0;
    d_is = 0; d_ws = 0; rel_cnt = 0; wa_len = 0; ra_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_is = init_state; p_ws = work_state;
        p_wa = 0; p_ra = 0; p_done = 0;
        d_is = 0; d_ws = 0; rel_cnt = 0; wa_len = 0; ra_len = 0;
      end else begin
        rel_cnt++;
        if (init_state != p_is) begin
          emit(EV_IS, (d_is << 8) | int'(init_state));
          d_is = 1;
          p_is = init_state;
        end else d_is++;
        if (sdram_init_done && !p_done) emit(EV_DN, rel_cnt);
        p_done = sdram_init_done;
        if (work_state != p_ws) begin
          emit(EV_WS, (d_ws << 8) | (int'(sdram_rd_wr) << 7) | int'(work_state));
          d_ws = 1;
          p_ws = work_state;
        end else d_ws++;
        if (sdram_wr_ack && !p_wa) emit(EV_WR, (int'(work_state) << 10) | int'(cnt_clk));
        if (sdram_wr_ack) wa_len++;
        if (!sdram_wr_ack && p_wa) begin
          emit(EV_WF, wa_len);
          wa_len = 0;
        end
        p_wa = sdram_wr_ack;
        if (sdram_rd_ack && !p_ra) emit(EV_RR, int'(cnt_clk));
        if (sdram_rd_ack) ra_len++;
        if (!sdram_rd_ack && p_ra) begin
          emit(EV_RF, ra_len);
          ra_len = 0;
        end
        p_ra = sdram_rd_ack;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    check_reset_values("reset");
    push_init_seq();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_is(7, 100);

    // First refresh after init, then write burst 8
    do_refresh();
    sdram_wr_burst = 10'd8;
    push_write(8);
    sdram_wr_req = 1'b1;
    wait_ws(1, 5);
    sdram_wr_req = 1'b0;
    wait_ws(0, 40);

    // Read burst 4
    do_refresh();
    sdram_rd_burst = 10'd4;
    push_read(4, 0);
    sdram_rd_req = 1'b1;
    wait_ws(1, 5);
    sdram_rd_req = 1'b0;
    wait_ws(0, 40);

    // Simultaneous requests with minimum bursts: write wins, read follows
    do_refresh();
    sdram_wr_burst = 10'd2;
    sdram_rd_burst = 10'd1;
    push_write(2);
    push_read(1, 0);
    sdram_wr_req = 1'b1;
    sdram_rd_req = 1'b1;
    wait_ws(1, 5);
    sdram_wr_req = 1'b0;
    wait_ws(0, 40);
    wait_ws(1, 5);
    sdram_rd_req = 1'b0;
    wait_ws(0, 40);

    // Long write spans several timer wraps; one refresh follows, ahead of
    // the read that was pending during the write
    do_refresh();
    sdram_wr_burst = 10'd256;
    sdram_rd_burst = 10'd4;
    push_write(256);
    push_refresh();
    push_read(4, 0);
    push_refresh();
    sdram_wr_req = 1'b1;
    wait_ws(1, 5);
    sdram_wr_req = 1'b0;
    sdram_rd_req = 1'b1;
    wait_ws(11, 400);
    wait_ws(1, 30);
    sdram_rd_req = 1'b0;
    wait_ws(11, 80);
    wait_ws(0, 20);

    // Reset in the middle of W_RD
    push_read(4, 1);
    sdram_rd_req = 1'b1;
    wait_ws(1, 5);
    sdram_rd_req = 1'b0;
    begin
      bit hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(negedge clk);
        if (work_state == 4'd5 && cnt_clk == 10'd2) hit = 1;
      end
      if (!hit) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_rd_mid: got state %0d expected 5 within 40 cycles", work_state);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    chk("queue_drained_at_reset", exp_q.size(), 0);
    push_init_seq();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_is(7, 100);
    repeat (3) @(negedge clk);
    chk("work_state_after_reinit", int'(work_state), 0);
    chk("queue_drained_at_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
